// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: two-requester arbiter feeding one shared bitwise unit into a result register; round-robin when LOGIC_ARB_RR_EN is defined, fixed priority otherwise
module logic_unit_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [1:0]  req0_op,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_src,
  output logic [7:0]  acc0_cnt,
  output logic [7:0]  acc1_cnt
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  logic [0:0]  state;
  logic        can_accept;
  logic        pref1;
  logic        sel1;
  logic        acc0;
  logic        acc1;
  logic        accept;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
`ifdef LOGIC_ARB_RR_EN
  logic last;
  assign pref1 = !last;
  // last-grant pointer moves only when a request is actually accepted
  always_ff @(posedge clk)
    if (reset) last <= 1'b1;
    else if (accept) last <= sel1;
`else
  assign pref1 = 1'b0;
`endif
  // grant, handshake and the single shared bitwise unit on the granted operands
  always_comb begin
    can_accept = !reset && (state == IDLE || rsp_ready);
    sel1       = req1_valid && (!req0_valid || pref1);
    req0_ready = can_accept && !sel1;
    req1_ready = can_accept && sel1;
    acc0       = req0_valid && req0_ready;
    acc1       = req1_valid && req1_ready;
    accept     = acc0 || acc1;
    op         = sel1 ? req1_op : req0_op;
    a          = sel1 ? req1_a : req0_a;
    b          = sel1 ? req1_b : req0_b;
    result     = op == 2'b00 ? (a & b) :
                 op == 2'b01 ? (a | b) :
                 op == 2'b10 ? (a ^ b) : ~(a | b);
  end
  assign rsp_valid = state == HOLD;
  // result register: load on accept, drain to IDLE when consumed with nothing new
  always_ff @(posedge clk)
    if (reset) begin
      state    <= IDLE;
      rsp_data <= 32'h0;
      rsp_src  <= 1'b0;
    end else if (accept) begin
      state    <= HOLD;
      rsp_data <= result;
      rsp_src  <= sel1;
    end else if (rsp_ready) begin
      state    <= IDLE;
    end
  // per-requester accept counters that stick at 8'hFF
  always_ff @(posedge clk)
    if (reset) begin
      acc0_cnt <= 8'h0;
      acc1_cnt <= 8'h0;
    end else begin
      acc0_cnt <= acc0_cnt + 8'((acc0 && acc0_cnt != 8'hFF) ? 1 : 0);
      acc1_cnt <= acc1_cnt + 8'((acc1 && acc1_cnt != 8'hFF) ? 1 : 0);
    end
endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 req0_valid / req1_valid  input  1 each  requester 0/1 has an operation pending.
REQ-004 req0_ready / req1_ready  output  1 each  operation accepted this cycle when valid and ready are both high.
REQ-005 req0_op / req1_op  input  2 each  00=AND, 01=OR, 10=XOR, 11=NOR.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32 each  operands.
REQ-007 rsp_valid  output  1  result register holds an unconsumed result.
REQ-008 rsp_ready  input  1  consumer accepts the result this cycle.
REQ-009 rsp_data  output  32  registered bitwise result.
REQ-010 rsp_src  output  1  index of the requester that produced rsp_data.
REQ-011 acc0_cnt / acc1_cnt  output  8 each  saturating count of accepted operations per requester.

Function
REQ-012 A single shared 32-bit bitwise unit SHALL compute the result of the granted request combinationally; no other datapath copy is permitted.
REQ-013 FSM states: IDLE (rsp_valid=0) and HOLD (rsp_valid=1).
REQ-014 can_accept = (state==IDLE) | (state==HOLD & rsp_ready).
REQ-015 At most one reqN_ready SHALL be high per cycle, and only when can_accept=1 and that requester is granted.
REQ-016 Grant: if only one requester is valid, it is granted; if both are valid, the arbitration policy (REQ-027/028) decides.
REQ-017 On accept: rsp_data <= op(a,b), rsp_src <= granted index, state <= HOLD; latency is exactly 1 cycle from accept to rsp_valid.
REQ-018 HOLD & rsp_ready & no accept: state <= IDLE; rsp_data and rsp_src retain their values.
REQ-019 HOLD & rsp_ready & accept: back-to-back; state stays HOLD and rsp_data/rsp_src update, giving one result per cycle throughput.
REQ-020 HOLD & !rsp_ready: reqN_ready=0 for both requesters; rsp_data and rsp_src are stable.
REQ-021 ready SHALL NOT depend on the requester's own valid, except through the grant when both requesters are valid.
REQ-022 accN_cnt increments by 1 on each accept from requester N and saturates at 8'hFF with no wrap.
REQ-023 Requests with valid=0 SHALL NOT alter any state or counters.

Reset
REQ-024 When reset=1 at a clk edge: state=IDLE, rsp_valid=0, rsp_data=32'h0, rsp_src=0, acc0_cnt=acc1_cnt=0, last-grant pointer=1 (requester 0 wins first tie).
REQ-025 reqN_ready SHALL be 0 during any cycle in which reset is high.
REQ-026 Reset asserted in HOLD discards the pending result without requiring rsp_ready.

Configuration
REQ-027 With LOGIC_ARB_RR_EN defined: round-robin arbitration; on a tie the requester not granted last wins, and the last-grant pointer updates only on accept.
REQ-028 Without LOGIC_ARB_RR_EN: fixed priority, requester 0 always wins ties; the pointer is absent and REQ-024 pointer reset does not apply.

Verification
REQ-029 Reset, then req0 valid op=01, a=32'hF0F0_0000, b=32'h0000_0F0F, rsp_ready=1 -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_data=32'hF0F0_0F0F, rsp_src=0, acc0_cnt=1.
REQ-030 Both requesters valid for 4 cycles, rsp_ready=1, with RR_EN -> grants 0,1,0,1 and rsp_data alternates per op; without RR_EN -> grants 0,0,0,0 and req1_ready=0.
REQ-031 Result pending, rsp_ready=0 for 3 cycles with req1 valid -> req1_ready=0 and rsp_data stable; rsp_ready=1 -> req1 accepted the same cycle and its result appears the next cycle.
REQ-032 op=11 with a=b=32'h0 -> rsp_data=32'hFFFF_FFFF; op=10 with a=b=32'hA5A5_A5A5 -> rsp_data=32'h0.
REQ-033 Run 300 accepts from req0 -> acc0_cnt=8'hFF, holding at 8'hFF with no wrap; acc1_cnt=0.
REQ-034 reset=1 asserted in HOLD with rsp_ready=0 -> next cycle rsp_valid=0, rsp_data=0, counters=0.
